// File: rtl/reed_conditioner_if.sv
// Reed conditioner signal bundle: the raw reed/enable inputs and the
// conditioned revolution pulse, period measurement and stall flag.
interface reed_conditioner_if #(
   parameter int PER_W = 14
);
   logic             reed_raw;
   logic             enable;
   logic             reed_pulse;
   logic [PER_W-1:0] period;
   logic             period_valid;
   logic             stalled;

   // Driver side (stimulus / upstream logic)
   modport master (
      output reed_raw,
      output enable,
      input  reed_pulse,
      input  period,
      input  period_valid,
      input  stalled
   );

   // Conditioner side
   modport slave (
      input  reed_raw,
      input  enable,
      output reed_pulse,
      output period,
      output period_valid,
      output stalled
   );
endinterface

// File: rtl/reed_conditioner.sv
// Reed switch conditioner: synchronizes and debounces a bouncing reed input,
// emits one strobe per wheel revolution and measures the revolution period
// in clock cycles, flagging a stalled wheel when the period counter saturates.
module reed_conditioner #(
   parameter int DEB_CYCLES = 4,
   parameter int PER_W      = 14
) (
   input  logic             clock,
   input  logic             reset,
   reed_conditioner_if.slave bus
);
   localparam logic [1:0] ST_OPEN    = 2'd0;
   localparam logic [1:0] ST_CLOSING = 2'd1;
   localparam logic [1:0] ST_CLOSED  = 2'd2;
   localparam logic [1:0] ST_OPENING = 2'd3;

   localparam logic [7:0]       DEB_LAST = 8'(DEB_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_MAX  = '1;

   logic             sync1_q;
   logic             sync_q;
   logic [1:0]       state_q, state_d;
   logic [7:0]       deb_cnt_q, deb_cnt_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic             seen_q, seen_d;
   logic             pulse_q, pulse_d;
   logic [PER_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             stalled_q, stalled_d;
   logic             accept;

   // Debounce FSM next state: a level change is accepted only after
   // DEB_CYCLES consecutive agreeing synchronized samples.
   always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      case (state_q)
         ST_OPEN: begin
            if (sync_q) begin
               state_d   = ST_CLOSING;
               deb_cnt_d = 8'd1;
            end
         end
         ST_CLOSING: begin
            if (!sync_q)                    state_d   = ST_OPEN;
            else if (deb_cnt_q == DEB_LAST) state_d   = ST_CLOSED;
            else                            deb_cnt_d = deb_cnt_q + 8'd1;
         end
         ST_CLOSED: begin
            if (!sync_q) begin
               state_d   = ST_OPENING;
               deb_cnt_d = 8'd1;
            end
         end
         ST_OPENING: begin
            if (sync_q)                     state_d   = ST_CLOSED;
            else if (deb_cnt_q == DEB_LAST) state_d   = ST_OPEN;
            else                            deb_cnt_d = deb_cnt_q + 8'd1;
         end
         default: state_d = ST_OPEN;
      endcase
   end

   // A revolution counts only on the debounced closing edge while enabled;
   // a release bounce (OPENING -> CLOSED) never counts.
   assign accept = (state_q == ST_CLOSING) && sync_q &&
                   (deb_cnt_q == DEB_LAST) && bus.enable;

   // Period measurement next state: saturating cycle counter, period capture
   // on each revolution after the first, stall flag on saturation.
   always_comb begin
      per_cnt_d = per_cnt_q;
      seen_d    = seen_q;
      pulse_d   = accept;
      period_d  = period_q;
      valid_d   = 1'b0;
      stalled_d = stalled_q;
      if (accept) begin
         per_cnt_d = '0;
         seen_d    = 1'b1;
         if (seen_q && (per_cnt_q != PER_MAX)) begin
            period_d  = per_cnt_q + 1'b1;
            valid_d   = 1'b1;
            stalled_d = 1'b0;
         end
      end else if (bus.enable && (per_cnt_q != PER_MAX)) begin
         per_cnt_d = per_cnt_q + 1'b1;
         if (per_cnt_q == PER_MAX - 1'b1) stalled_d = 1'b1;
      end
   end

   // State registers; reset overrides everything, including a debounce
   // in progress, so an interrupted closure must debounce again from scratch.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync_q    <= 1'b0;
         state_q   <= ST_OPEN;
         deb_cnt_q <= 8'd0;
         per_cnt_q <= '0;
         seen_q    <= 1'b0;
         pulse_q   <= 1'b0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         stalled_q <= 1'b1;
      end else begin
         sync1_q   <= bus.reed_raw;
         sync_q    <= sync1_q;
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
         per_cnt_q <= per_cnt_d;
         seen_q    <= seen_d;
         pulse_q   <= pulse_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         stalled_q <= stalled_d;
      end
   end

   assign bus.reed_pulse   = pulse_q;
   assign bus.period       = period_q;
   assign bus.period_valid = valid_q;
   assign bus.stalled      = stalled_q;
endmodule

// File: tb/tb_reed_conditioner.sv
// Testbench for reed_conditioner: directed vector table, hand-written
// multi-cycle sequences, randomized bouncing input, and a cycle-by-cycle
// behavioural reference model running in the background.
module tb_reed_conditioner;
   localparam int DEB  = 4;
   localparam int PW   = 14;
   localparam int MAXC = (1 << PW) - 1;

   logic clock;
   logic reset;

   reed_conditioner_if #(.PER_W(PW)) bus_if ();

   reed_conditioner #(.DEB_CYCLES(DEB), .PER_W(PW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int passed;
   int total;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   // Debounced level flips once the synchronized input (the raw input two
   // edges earlier) has disagreed with it for DEB consecutive edges. The
   // period is the number of enabled edges since the previous revolution.
   bit m_on, m_r1, m_r2, m_lvl, m_have_prev;
   int m_run, m_since;
   bit m_pulse, m_valid, m_stalled;
   int m_period;

   initial begin
      bit s, raw_now, en_now, rst_now;
      m_on = 1'b0;
      forever begin
         @(posedge clock);
         raw_now = bus_if.reed_raw;
         en_now  = bus_if.enable;
         rst_now = reset;
         if (rst_now) begin
            m_on = 1'b1;
            m_r1 = 1'b0; m_r2 = 1'b0; m_lvl = 1'b0; m_have_prev = 1'b0;
            m_run = 0; m_since = 0;
            m_pulse = 1'b0; m_valid = 1'b0; m_stalled = 1'b1; m_period = 0;
         end else if (m_on) begin
            s = m_r2;
            m_r2 = m_r1;
            m_r1 = raw_now;
            m_pulse = 1'b0;
            m_valid = 1'b0;
            if (s != m_lvl) begin
               m_run++;
               if (m_run == DEB) begin
                  m_lvl = s;
                  m_run = 0;
                  m_pulse = s && en_now;
               end
            end else begin
               m_run = 0;
            end
            if (m_pulse) begin
               if (m_have_prev && m_since < MAXC) begin
                  m_period  = m_since + 1;
                  m_valid   = 1'b1;
                  m_stalled = 1'b0;
               end
               m_have_prev = 1'b1;
               m_since = 0;
            end else if (en_now && m_since < MAXC) begin
               m_since++;
               if (m_since == MAXC) m_stalled = 1'b1;
            end
         end
         #1;
         if (m_on) begin
            check("model_outputs",
                  {bus_if.reed_pulse, bus_if.period_valid, bus_if.stalled, 15'(bus_if.period)},
                  {m_pulse, m_valid, m_stalled, 15'(m_period)});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(bit r, bit e);
      @(negedge clock);
      reset = 1'b0;
      bus_if.reed_raw = r;
      bus_if.enable = e;
      @(posedge clock);
      #1;
   endtask

   task automatic rst_step(bit r);
      @(negedge clock);
      reset = 1'b1;
      bus_if.reed_raw = r;
      bus_if.enable = 1'b1;
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      int len;
      int gap;
      bit en;
      int exp_pulses;
      int exp_first;
      int exp_valids;
      bit exp_stalled;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int pulses, first, valids, npulse;
      bit en_r, lvl;
      int len;
      passed = 0;
      total  = 0;
      reset = 1'b0;
      bus_if.reed_raw = 1'b0;
      bus_if.enable = 1'b1;

      // {raw high edges, raw low edges, enable, pulses, first pulse edge, valids, stalled at end}
      tbl[0] = '{20, 20, 1'b1, 1, 6, 0, 1'b1};
      tbl[1] = '{ 3, 10, 1'b1, 0, 0, 0, 1'b1};
      tbl[2] = '{ 2, 10, 1'b1, 0, 0, 0, 1'b1};
      tbl[3] = '{ 4, 10, 1'b1, 1, 6, 1, 1'b0};
      tbl[4] = '{ 4, 10, 1'b0, 0, 0, 0, 1'b0};
      tbl[5] = '{ 8, 10, 1'b1, 1, 6, 1, 1'b0};
      tbl[6] = '{ 1, 10, 1'b1, 0, 0, 0, 1'b0};

      // Reset values
      rst_step(1'b0);
      check("rst_pulse", 32'(bus_if.reed_pulse), 0);
      check("rst_valid", 32'(bus_if.period_valid), 0);
      check("rst_period", 32'(bus_if.period), 0);
      check("rst_stalled", 32'(bus_if.stalled), 1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);

      // Vector table
      for (int v = 0; v < 7; v++) begin
         pulses = 0; first = 0; valids = 0;
         for (int n = 1; n <= tbl[v].len + tbl[v].gap; n++) begin
            step(n <= tbl[v].len, tbl[v].en);
            if (bus_if.reed_pulse) begin
               pulses++;
               if (first == 0) first = n;
            end
            if (bus_if.period_valid) valids++;
         end
         check($sformatf("tbl%0d_pulses", v), pulses, tbl[v].exp_pulses);
         check($sformatf("tbl%0d_first", v), first, tbl[v].exp_first);
         check($sformatf("tbl%0d_valids", v), valids, tbl[v].exp_valids);
         check($sformatf("tbl%0d_stalled", v), 32'(bus_if.stalled), 32'(tbl[v].exp_stalled));
      end

      // Bounce: 3 high, 1 low, then held high -> one pulse 5 edges after second rise
      rst_step(1'b0);
      npulse = 0; first = 0;
      for (int n = 1; n <= 16; n++) begin
         step((n <= 3) || (n >= 5), 1'b1);
         if (bus_if.reed_pulse) begin
            npulse++;
            if (first == 0) first = n;
         end
      end
      check("bounce_pulses", npulse, 1);
      check("bounce_first", first, 10);
      for (int n = 0; n < 10; n++) step(1'b0, 1'b1);

      // Two closures 100 edges apart -> period 100
      rst_step(1'b0);
      npulse = 0;
      for (int n = 1; n <= 108; n++) begin
         step((n <= 8) || (n >= 101), 1'b1);
         if (bus_if.reed_pulse) npulse++;
         if (n == 6) begin
            check("p1_pulse", 32'(bus_if.reed_pulse), 1);
            check("p1_valid", 32'(bus_if.period_valid), 0);
            check("p1_stalled", 32'(bus_if.stalled), 1);
         end
         if (n == 106) begin
            check("p2_pulse", 32'(bus_if.reed_pulse), 1);
            check("p2_valid", 32'(bus_if.period_valid), 1);
            check("p2_period", 32'(bus_if.period), 100);
            check("p2_stalled", 32'(bus_if.stalled), 0);
         end
      end
      check("p_pulse_count", npulse, 2);

      // Stall: counter saturates 16383 edges after the last revolution
      for (int i = 1; i <= 16400; i++) begin
         step(1'b0, 1'b1);
         if (i == 16380) check("stall_before", 32'(bus_if.stalled), 0);
         if (i == 16381) check("stall_at_sat", 32'(bus_if.stalled), 1);
      end
      check("stall_period_held", 32'(bus_if.period), 100);
      for (int n = 1; n <= 8; n++) begin
         step(1'b1, 1'b1);
         if (n == 6) begin
            check("stall_pulse", 32'(bus_if.reed_pulse), 1);
            check("stall_valid", 32'(bus_if.period_valid), 0);
            check("stall_still", 32'(bus_if.stalled), 1);
            check("stall_period", 32'(bus_if.period), 100);
         end
      end
      for (int n = 0; n < 10; n++) step(1'b0, 1'b1);

      // Enable low through a full closure, raised while closed; counter frozen
      rst_step(1'b0);
      npulse = 0;
      for (int n = 1; n <= 68; n++) begin
         en_r = !((n >= 21) && (n <= 40));
         step((n <= 8) || ((n >= 21) && (n <= 50)) || (n >= 61), en_r);
         if (n >= 7 && n <= 65 && bus_if.reed_pulse) npulse++;
         if (n == 66) begin
            check("en_pulse", 32'(bus_if.reed_pulse), 1);
            check("en_valid", 32'(bus_if.period_valid), 1);
            check("en_period", 32'(bus_if.period), 40);
         end
      end
      check("en_no_pulse", npulse, 0);

      // Reset in the middle of a debounce
      for (int n = 0; n < 10; n++) step(1'b0, 1'b1);
      for (int n = 1; n <= 5; n++) step(1'b1, 1'b1);
      rst_step(1'b1);
      check("mid_rst_pulse", 32'(bus_if.reed_pulse), 0);
      check("mid_rst_valid", 32'(bus_if.period_valid), 0);
      check("mid_rst_period", 32'(bus_if.period), 0);
      check("mid_rst_stalled", 32'(bus_if.stalled), 1);
      first = 0;
      for (int n = 1; n <= 10; n++) begin
         step(1'b1, 1'b1);
         if (bus_if.reed_pulse && first == 0) first = n;
      end
      check("mid_rst_first", first, DEB + 2);
      for (int n = 0; n < 10; n++) step(1'b0, 1'b1);

      // Randomized bouncing input against the reference model
      en_r = 1'b1;
      for (int seg = 0; seg < 400; seg++) begin
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         if ($urandom_range(0, 7) == 0) en_r = ~en_r;
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 299) == 0) rst_step(lvl);
            else step(lvl, en_r);
         end
      end

      @(negedge clock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
